// File: rtl/core_wb_arbiter.sv
// rtl/core_wb_arbiter.sv - writeback arbiter and long-latency pending scoreboard
//
// Purpose:
//   Arbitrates three result channels (LSU > MDU > ALU, fixed priority) onto a
//   single registered register-file write port. It also tracks destination
//   registers of outstanding long-latency ops (loads, multiply/divide) and
//   raises a decode hazard.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   {alu,lsu,mdu}_wb_vld/rdy/idx/dat   result channels (vld/rdy handshake)
//   lng_alloc_vld, lng_alloc_idx       long-latency op issued to lng_alloc_idx
//   chk_src1_idx, chk_src2_idx,
//   chk_dest_idx, chk_hazard           decode hazard query
//   wb_dest_wen/idx/dat                registered register-file write port
module core_wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               alu_wb_vld,
  output logic               alu_wb_rdy,
  input  logic [RFIDX_W-1:0] alu_wb_idx,
  input  logic [XLEN-1:0]    alu_wb_dat,

  input  logic               lsu_wb_vld,
  output logic               lsu_wb_rdy,
  input  logic [RFIDX_W-1:0] lsu_wb_idx,
  input  logic [XLEN-1:0]    lsu_wb_dat,

  input  logic               mdu_wb_vld,
  output logic               mdu_wb_rdy,
  input  logic [RFIDX_W-1:0] mdu_wb_idx,
  input  logic [XLEN-1:0]    mdu_wb_dat,

  input  logic               lng_alloc_vld,
  input  logic [RFIDX_W-1:0] lng_alloc_idx,

  input  logic [RFIDX_W-1:0] chk_src1_idx,
  input  logic [RFIDX_W-1:0] chk_src2_idx,
  input  logic [RFIDX_W-1:0] chk_dest_idx,
  output logic               chk_hazard,

  output logic               wb_dest_wen,
  output logic [RFIDX_W-1:0] wb_dest_idx,
  output logic [XLEN-1:0]    wb_dest_dat
);

  localparam int NREG = 1 << RFIDX_W;

  logic               lsu_gnt;
  logic               mdu_gnt;
  logic               alu_gnt;
  logic               any_gnt;
  logic [RFIDX_W-1:0] win_idx;
  logic [XLEN-1:0]    win_dat;

  logic               wen_q, wen_d;
  logic [RFIDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]    dat_q, dat_d;
  logic [NREG-1:0]    pend_q, pend_d;

  logic               src1_nz;
  logic               src2_nz;
  logic               dest_nz;

  // Grants depend only on the vld bits (never idx/dat) and are gated by rst
  // so that no transfer can happen while the block is being reset.
  always_comb begin
    lsu_gnt = ~rst & lsu_wb_vld;
    mdu_gnt = ~rst & mdu_wb_vld & ~lsu_wb_vld;
    alu_gnt = ~rst & alu_wb_vld & ~lsu_wb_vld & ~mdu_wb_vld;
    any_gnt = lsu_gnt | mdu_gnt | alu_gnt;
  end

  assign lsu_wb_rdy = lsu_gnt;
  assign mdu_wb_rdy = mdu_gnt;
  assign alu_wb_rdy = alu_gnt;

  always_comb begin
    win_idx = alu_wb_idx;
    win_dat = alu_wb_dat;
    if (lsu_gnt) begin
      win_idx = lsu_wb_idx;
      win_dat = lsu_wb_dat;
    end else if (mdu_gnt) begin
      win_idx = mdu_wb_idx;
      win_dat = mdu_wb_dat;
    end
  end

  // A transfer to x0 is accepted and recorded, but never writes the file.
  always_comb begin
    wen_d = 1'b0;
    idx_d = idx_q;
    dat_d = dat_q;
    if (any_gnt) begin
      wen_d = (win_idx != '0);
      idx_d = win_idx;
      dat_d = win_dat;
    end
  end

  // Clear before set: a same-cycle allocation to the register being retired
  // belongs to a newer op, so the bit must stay set.
  always_comb begin
    pend_d = pend_q;
    if (lsu_gnt | mdu_gnt) begin
      pend_d[win_idx] = 1'b0;
    end
    if (lng_alloc_vld) begin
      pend_d[lng_alloc_idx] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      idx_q  <= '0;
      dat_q  <= '0;
      pend_q <= '0;
    end else begin
      wen_q  <= wen_d;
      idx_q  <= idx_d;
      dat_q  <= dat_d;
      pend_q <= pend_d;
    end
  end

  assign wb_dest_wen = wen_q;
  assign wb_dest_idx = idx_q;
  assign wb_dest_dat = dat_q;

  // The registered write is not yet in the register file, so sources that
  // match it must also stall for one cycle.
  always_comb begin
    src1_nz    = (chk_src1_idx != '0);
    src2_nz    = (chk_src2_idx != '0);
    dest_nz    = (chk_dest_idx != '0);
    chk_hazard = (src1_nz & pend_q[chk_src1_idx])
               | (src2_nz & pend_q[chk_src2_idx])
               | (dest_nz & pend_q[chk_dest_idx])
               | (wen_q & ((src1_nz & (idx_q == chk_src1_idx))
                         | (src2_nz & (idx_q == chk_src2_idx))));
  end

  // Sources that are stalled must hold their payload.
  alu_hold_a: assert property (@(posedge clk) disable iff (rst)
    (alu_wb_vld && !alu_wb_rdy) |=>
      (!alu_wb_vld || ($stable(alu_wb_idx) && $stable(alu_wb_dat))));
  lsu_hold_a: assert property (@(posedge clk) disable iff (rst)
    (lsu_wb_vld && !lsu_wb_rdy) |=>
      (!lsu_wb_vld || ($stable(lsu_wb_idx) && $stable(lsu_wb_dat))));
  mdu_hold_a: assert property (@(posedge clk) disable iff (rst)
    (mdu_wb_vld && !mdu_wb_rdy) |=>
      (!mdu_wb_vld || ($stable(mdu_wb_idx) && $stable(mdu_wb_dat))));

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb/tb_core_wb_arbiter.sv - scoreboard bench for core_wb_arbiter
module tb_core_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wb_vld = 1'b0, lsu_wb_vld = 1'b0, mdu_wb_vld = 1'b0;
  logic        alu_wb_rdy, lsu_wb_rdy, mdu_wb_rdy;
  logic [4:0]  alu_wb_idx = '0, lsu_wb_idx = '0, mdu_wb_idx = '0;
  logic [31:0] alu_wb_dat = '0, lsu_wb_dat = '0, mdu_wb_dat = '0;
  logic        lng_alloc_vld = 1'b0;
  logic [4:0]  lng_alloc_idx = '0;
  logic [4:0]  chk_src1_idx = '0, chk_src2_idx = '0, chk_dest_idx = '0;
  logic        chk_hazard;
  logic        wb_dest_wen;
  logic [4:0]  wb_dest_idx;
  logic [31:0] wb_dest_dat;

  core_wb_arbiter #(.XLEN(32), .RFIDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_vld(alu_wb_vld), .alu_wb_rdy(alu_wb_rdy), .alu_wb_idx(alu_wb_idx), .alu_wb_dat(alu_wb_dat),
    .lsu_wb_vld(lsu_wb_vld), .lsu_wb_rdy(lsu_wb_rdy), .lsu_wb_idx(lsu_wb_idx), .lsu_wb_dat(lsu_wb_dat),
    .mdu_wb_vld(mdu_wb_vld), .mdu_wb_rdy(mdu_wb_rdy), .mdu_wb_idx(mdu_wb_idx), .mdu_wb_dat(mdu_wb_dat),
    .lng_alloc_vld(lng_alloc_vld), .lng_alloc_idx(lng_alloc_idx),
    .chk_src1_idx(chk_src1_idx), .chk_src2_idx(chk_src2_idx), .chk_dest_idx(chk_dest_idx),
    .chk_hazard(chk_hazard),
    .wb_dest_wen(wb_dest_wen), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  idx;
    logic [31:0] dat;
    logic        known;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  logic [31:0] pend_m  = '0;
  logic        m_wen   = 1'b0;
  logic [4:0]  m_idx   = '0;
  logic [31:0] m_dat   = '0;
  logic        m_known = 1'b0;
  logic        started = 1'b0;
  logic [2:0]  last_g  = 3'b000;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check combinational outputs, push the expected write, cross
  // the edge, then pop and compare the registered write port.
  task automatic step(input int exp_haz);
    logic [2:0]  g;
    logic        h;
    logic [4:0]  wi;
    logic [31:0] wd;
    exp_t        e;
    #1;
    g = 3'b000;
    if (!rst) begin
      if (lsu_wb_vld)      g = 3'b100;
      else if (mdu_wb_vld) g = 3'b010;
      else if (alu_wb_vld) g = 3'b001;
    end
    check_eq("rdy", 64'({lsu_wb_rdy, mdu_wb_rdy, alu_wb_rdy}), 64'(g));

    h = (chk_src1_idx != 0 && pend_m[chk_src1_idx])
     || (chk_src2_idx != 0 && pend_m[chk_src2_idx])
     || (chk_dest_idx != 0 && pend_m[chk_dest_idx])
     || (m_wen && ((chk_src1_idx != 0 && m_idx == chk_src1_idx)
                || (chk_src2_idx != 0 && m_idx == chk_src2_idx)));
    if (started) check_eq("hazard", 64'(chk_hazard), 64'(h));
    if (exp_haz >= 0) check_eq("hazard_dir", 64'(chk_hazard), 64'(exp_haz));

    if (g[2]) begin
      wi = lsu_wb_idx; wd = lsu_wb_dat;
    end else if (g[1]) begin
      wi = mdu_wb_idx; wd = mdu_wb_dat;
    end else begin
      wi = alu_wb_idx; wd = alu_wb_dat;
    end

    if (rst)
      e = '{wen: 1'b0, idx: 5'd0, dat: 32'd0, known: 1'b1};
    else if (g != 3'b000)
      e = '{wen: (wi != 0), idx: wi, dat: wd, known: (wi != 0)};
    else
      e = '{wen: 1'b0, idx: m_idx, dat: m_dat, known: m_known};

    if (rst) begin
      pend_m = '0;
    end else begin
      if (g[2] || g[1]) pend_m[wi] = 1'b0;
      if (lng_alloc_vld && lng_alloc_idx != 0) pend_m[lng_alloc_idx] = 1'b1;
    end
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("wen", 64'(wb_dest_wen), 64'(e.wen));
    if (e.known) begin
      check_eq("wb_idx", 64'(wb_dest_idx), 64'(e.idx));
      check_eq("wb_dat", 64'(wb_dest_dat), 64'(e.dat));
    end
    m_wen   = e.wen;
    m_idx   = e.idx;
    m_dat   = e.dat;
    m_known = e.known;
    started = 1'b1;
    last_g  = g;
  endtask

  task automatic idle_inputs();
    alu_wb_vld = 1'b0; lsu_wb_vld = 1'b0; mdu_wb_vld = 1'b0;
    lng_alloc_vld = 1'b0; lng_alloc_idx = '0;
    chk_src1_idx = '0; chk_src2_idx = '0; chk_dest_idx = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst = 1'b1;
    step(-1);
    step(0);
    rst = 1'b0;

    // ALU only
    alu_wb_vld = 1'b1; alu_wb_idx = 5'd5; alu_wb_dat = 32'hDEADBEEF;
    step(0);
    check_eq("alu_wen", 64'(wb_dest_wen), 64'(1));
    idle_inputs();
    step(0);
    check_eq("alu_wen_drop", 64'(wb_dest_wen), 64'(0));

    // contention: LSU, then MDU, then ALU
    lsu_wb_vld = 1'b1; lsu_wb_idx = 5'd1; lsu_wb_dat = 32'h11111111;
    mdu_wb_vld = 1'b1; mdu_wb_idx = 5'd2; mdu_wb_dat = 32'h22222222;
    alu_wb_vld = 1'b1; alu_wb_idx = 5'd3; alu_wb_dat = 32'h33333333;
    step(-1);
    check_eq("cont_lsu_idx", 64'(wb_dest_idx), 64'(1));
    lsu_wb_vld = 1'b0;
    step(-1);
    check_eq("cont_mdu_idx", 64'(wb_dest_idx), 64'(2));
    mdu_wb_vld = 1'b0;
    step(-1);
    check_eq("cont_alu_idx", 64'(wb_dest_idx), 64'(3));
    idle_inputs();
    step(-1);

    // pending scoreboard on idx 7
    lng_alloc_vld = 1'b1; lng_alloc_idx = 5'd7; chk_src1_idx = 5'd7;
    step(0);
    lng_alloc_vld = 1'b0;
    step(1);
    step(1);
    lsu_wb_vld = 1'b1; lsu_wb_idx = 5'd7; lsu_wb_dat = 32'hCAFE0007;
    step(1);
    lsu_wb_vld = 1'b0;
    step(1);
    step(0);
    idle_inputs();

    // same-cycle alloc and clear on idx 9
    lng_alloc_vld = 1'b1; lng_alloc_idx = 5'd9;
    step(0);
    mdu_wb_vld = 1'b1; mdu_wb_idx = 5'd9; mdu_wb_dat = 32'h99999999;
    step(0);
    idle_inputs();
    chk_dest_idx = 5'd9;
    step(1);
    chk_dest_idx = 5'd0;
    mdu_wb_vld = 1'b1; mdu_wb_idx = 5'd9; mdu_wb_dat = 32'h99990000;
    step(0);
    idle_inputs();
    step(0);

    // x0 handling
    alu_wb_vld = 1'b1; alu_wb_idx = 5'd0; alu_wb_dat = 32'h00001234;
    step(0);
    check_eq("x0_wen", 64'(wb_dest_wen), 64'(0));
    idle_inputs();
    lng_alloc_vld = 1'b1; lng_alloc_idx = 5'd0; chk_src1_idx = 5'd0;
    step(0);
    lng_alloc_vld = 1'b0;
    step(0);

    // reset in the middle of traffic
    lng_alloc_vld = 1'b1; lng_alloc_idx = 5'd4;
    step(0);
    lng_alloc_vld = 1'b0; chk_src1_idx = 5'd4;
    alu_wb_vld = 1'b1; alu_wb_idx = 5'd6; alu_wb_dat = 32'hA5A5A5A5;
    step(1);
    rst = 1'b1;
    step(1);
    check_eq("rst_wen", 64'(wb_dest_wen), 64'(0));
    check_eq("rst_idx", 64'(wb_dest_idx), 64'(0));
    check_eq("rst_dat", 64'(wb_dest_dat), 64'(0));
    rst = 1'b0;
    step(0);
    idle_inputs();
    step(0);

    // random traffic; stalled sources hold their payload
    for (int n = 0; n < 400; n++) begin
      if (!(alu_wb_vld && !last_g[0])) begin
        alu_wb_vld = 1'($urandom_range(0, 1));
        alu_wb_idx = 5'($urandom_range(0, 15));
        alu_wb_dat = $urandom;
      end
      if (!(lsu_wb_vld && !last_g[2])) begin
        lsu_wb_vld = ($urandom_range(0, 2) == 0);
        lsu_wb_idx = 5'($urandom_range(0, 15));
        lsu_wb_dat = $urandom;
      end
      if (!(mdu_wb_vld && !last_g[1])) begin
        mdu_wb_vld = ($urandom_range(0, 2) == 0);
        mdu_wb_idx = 5'($urandom_range(0, 15));
        mdu_wb_dat = $urandom;
      end
      lng_alloc_vld = ($urandom_range(0, 2) == 0);
      lng_alloc_idx = 5'($urandom_range(0, 15));
      chk_src1_idx  = 5'($urandom_range(0, 15));
      chk_src2_idx  = 5'($urandom_range(0, 15));
      chk_dest_idx  = 5'($urandom_range(0, 15));
      rst = ($urandom_range(0, 63) == 0);
      step(-1);
    end
    rst = 1'b0;
    idle_inputs();
    step(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the register file.
REQ-002 SHALL have parameter RFIDX_W, default 5, register index width (2^RFIDX_W registers; x0 is hard zero).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports alu_wb_vld in 1, alu_wb_rdy out 1, alu_wb_idx in RFIDX_W, alu_wb_dat in XLEN: single-cycle ALU result channel.
REQ-006 SHALL have ports lsu_wb_vld in 1, lsu_wb_rdy out 1, lsu_wb_idx in RFIDX_W, lsu_wb_dat in XLEN: load-data result channel.
REQ-007 SHALL have ports mdu_wb_vld in 1, mdu_wb_rdy out 1, mdu_wb_idx in RFIDX_W, mdu_wb_dat in XLEN: multiply/divide result channel.
REQ-008 SHALL have ports lng_alloc_vld in 1, lng_alloc_idx in RFIDX_W: a long-latency op (load or MDU) was issued with this destination.
REQ-009 SHALL have ports chk_src1_idx in RFIDX_W, chk_src2_idx in RFIDX_W, chk_dest_idx in RFIDX_W: operand/destination indices of the instruction in decode.
REQ-010 SHALL have port chk_hazard  out  1  decode must stall.
REQ-011 SHALL have ports wb_dest_wen out 1, wb_dest_idx out RFIDX_W, wb_dest_dat out XLEN: register-file write port, all registered.

Function
REQ-012 SHALL grant at most one channel per cycle, fixed priority LSU > MDU > ALU among channels with vld=1.
REQ-013 SHALL drive xxx_wb_rdy combinationally: 1 only for the granted channel, 0 for all others; rdy never depends on a channel's own idx or dat.
REQ-014 SHALL treat a transfer as vld&rdy on a rising edge; a source holding vld with rdy=0 keeps idx/dat stable (source obligation, checked by assertion).
REQ-015 SHALL, on the edge after a transfer, present wb_dest_wen=1, wb_dest_idx and wb_dest_dat of the winner for exactly one cycle (latency 1).
REQ-016 SHALL accept a transfer with idx=0 but drive wb_dest_wen=0 in the following cycle.
REQ-017 SHALL drive wb_dest_wen=0 in any cycle following no transfer; wb_dest_idx/dat hold their last values.
REQ-018 SHALL keep a pending bitmask pend[2^RFIDX_W-1:1]; bit 0 is constant 0.
REQ-019 SHALL set pend[lng_alloc_idx] on lng_alloc_vld=1 (idx 0 ignored).
REQ-020 SHALL clear pend[idx] on an LSU or MDU transfer; ALU transfers never change pend.
REQ-021 SHALL, when allocation and a clearing transfer target the same idx in one cycle, leave the bit set (new op outstanding).
REQ-022 SHALL compute chk_hazard combinationally = pend[src1] | pend[src2] | pend[dest] | (wb_dest_wen & (wb_dest_idx==src1 | wb_dest_idx==src2)), with any index 0 contributing 0.
REQ-023 SHALL not check for, nor count, allocation to an already-pending idx; the bit simply stays 1.

Reset
REQ-024 SHALL, while rst=1, clear pend to all zeros and set wb_dest_wen=0, wb_dest_idx=0, wb_dest_dat=0 on the edge.
REQ-025 SHALL force all xxx_wb_rdy=0 while rst=1; no transfer occurs during reset.
REQ-026 SHALL, on rst asserted mid-operation, discard any pending bits and the registered write; first grant possible in the first cycle with rst=0.

Verification
REQ-027 ALU only: alu vld=1, idx=5, dat=0xDEADBEEF -> alu_rdy=1 same cycle; next cycle wen=1, idx=5, dat=0xDEADBEEF; following cycle wen=0.
REQ-028 Contention: all three vld same cycle (idx 1/2/3) -> LSU wins, then MDU, then ALU on three consecutive writes; rdy one-hot each cycle.
REQ-029 Scoreboard: alloc idx=7; decode src1=7 -> chk_hazard=1 until LSU idx=7 transfer; hazard still 1 the cycle wen=1 idx=7; 0 the cycle after.
REQ-030 Same-cycle alloc+clear on idx=9 -> pend[9] stays 1; chk_dest_idx=9 gives chk_hazard=1.
REQ-031 x0: ALU transfer idx=0 dat=0x1234 -> next-cycle wen=0; alloc idx=0 -> chk_hazard stays 0 for src1=0.
REQ-032 Reset mid-flight: pend[4]=1 and a transfer in progress, assert rst one cycle -> pend=0, wen=0, idx=0, dat=0, all rdy=0 during rst.
